btn_debounce: RTL and testbench

- Turns the raw board push-button into clean, single-cycle press/release events for the lab top levels.
- Synchronizes `btn_i` into `clk50_i` and filters contact bounce with a counter-based FSM.
- Emits `press_o` and `release_o` pulses plus a debounced level. Downstream logic (latch registers, event counters) consumes `press_o` in place of its own raw edge detector.

---
 rtl/btn_debounce.sv | 169 ++++++++++++++++
 tb/tb_btn_debounce.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button synchronizer and counter-based debouncer giving press/release pulses and a clean level.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses (flagged on repeat_o) while the button is held.
module btn_debounce #(
    parameter int unsigned SYNC_STAGES     = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk50_i,
    input  logic rstn_i,
    input  logic btn_i,
    output logic press_o,
    output logic release_o,
    output logic pressed_o,
    output logic repeat_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Entering a WAIT state already counts as the first stable sample, so the
    // accept point is one count early; a single-cycle filter still needs one WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   pressed_q, pressed_d;
    logic                   acc_press;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_press = 1'b0;
        release_d = 1'b0;
        pressed_d = pressed_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                    acc_press = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    pressed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_per_q, rpt_per_d;
    logic             repeat_q, repeat_d;
    logic [RPT_W-1:0] rpt_target;
    logic             rpt_fire;

    assign rpt_target = rpt_per_q ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY);

    // Timer only advances on cycles spent stably in PRESSED, so bounce in RELEASE_WAIT freezes it.
    always_comb begin
        rpt_d     = rpt_q;
        rpt_per_d = rpt_per_q;
        rpt_fire  = 1'b0;
        if (state_q == PRESSED && s) begin
            if (rpt_q + RPT_W'(1) == rpt_target) begin
                rpt_fire  = 1'b1;
                rpt_d     = '0;
                rpt_per_d = 1'b1;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
        if (acc_press || release_d) begin
            rpt_d     = '0;
            rpt_per_d = 1'b0;
        end
        press_d  = acc_press | rpt_fire;
        repeat_d = rpt_fire;
    end

    always_ff @(posedge clk50_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rpt_q     <= '0;
            rpt_per_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            rpt_q     <= rpt_d;
            rpt_per_q <= rpt_per_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_o = repeat_q;
`else
    assign press_d  = acc_press;
    assign repeat_o = 1'b0;
`endif

    always_ff @(posedge clk50_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            pressed_q <= pressed_d;
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign pressed_o = pressed_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed latency/glitch/reset scenarios plus random bounce
// compared every cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_btn_debounce;
    localparam int SYNC = 3;
    localparam int DC   = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;

    logic clk50_i = 1'b0;
    logic rstn_i;
    logic btn_i;
    logic press_o, release_o, pressed_o, repeat_o;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    btn_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk50_i  (clk50_i),
        .rstn_i   (rstn_i),
        .btn_i    (btn_i),
        .press_o  (press_o),
        .release_o(release_o),
        .pressed_o(pressed_o),
        .repeat_o (repeat_o)
    );

    always #10 clk50_i = ~clk50_i;

    // Reference: delay line for the synchronizer, then a run-length filter on the delayed level.
    bit sq[$];
    bit m_lvl, m_press, m_rel, m_rep;
    int m_run, m_tmr;

    always @(posedge clk50_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sq.delete();
            for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
            m_lvl = 0; m_run = 0; m_tmr = 0;
            m_press = 0; m_rel = 0; m_rep = 0;
        end else begin
            bit s;
            s = sq[SYNC-1];
            sq.push_front(btn_i);
            void'(sq.pop_back());
            m_press = 0; m_rel = 0; m_rep = 0;
            if (m_lvl && m_run == 0 && s) begin
                m_tmr++;
`ifdef BTN_AUTOREPEAT_EN
                if (m_tmr >= RD && (m_tmr - RD) % RP == 0) begin
                    m_press = 1; m_rep = 1;
                end
`endif
            end
            if (s != m_lvl) begin
                m_run++;
                if (m_run == DC) begin
                    m_lvl = s; m_run = 0; m_tmr = 0;
                    if (s) m_press = 1; else m_rel = 1;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    always @(negedge clk50_i) begin
        if (mon_en) begin
            total++;
            if ({press_o, release_o, pressed_o, repeat_o} !== {m_press, m_rel, m_lvl, m_rep}) begin
                bad++;
                $display("FAIL model_cmp t=%0t dut(press,rel,lvl,rep)=%b%b%b%b model=%b%b%b%b", $time,
                         press_o, release_o, pressed_o, repeat_o, m_press, m_rel, m_lvl, m_rep);
            end
            total++;
            if (press_o && release_o) begin
                bad++;
                $display("FAIL press_and_release t=%0t press=%b release=%b want not both", $time, press_o, release_o);
            end
        end
    end

    task automatic wait_pressed(input bit v);
        int n = 0;
        while (pressed_o !== v && n < 50) begin
            @(negedge clk50_i);
            n++;
        end
        total++;
        if (pressed_o !== v) begin
            bad++;
            $display("FAIL wait_pressed got=%b want=%b", pressed_o, v);
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        btn_i  = 1'b0;
        repeat (3) @(negedge clk50_i);
        total++;
        if ({press_o, release_o, pressed_o, repeat_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b%b%b%b want=0000", press_o, release_o, pressed_o, repeat_o);
        end
        #2 rstn_i = 1'b1;
        repeat (2) @(negedge clk50_i);
        total++;
        if ({press_o, release_o, pressed_o, repeat_o} !== 4'b0000) begin
            bad++;
            $display("FAIL post_reset_idle got=%b%b%b%b want=0000", press_o, release_o, pressed_o, repeat_o);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_press_latency();
        btn_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk50_i);
            total++;
            if (press_o !== (k == SYNC + DC - 1) || pressed_o !== (k >= SYNC + DC - 1) || release_o !== 1'b0) begin
                bad++;
                $display("FAIL press_latency k=%0d got press=%b lvl=%b rel=%b want press=%b lvl=%b rel=0",
                         k, press_o, pressed_o, release_o, k == SYNC + DC - 1, k >= SYNC + DC - 1);
            end
        end
        btn_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk50_i);
            total++;
            if (release_o !== (k == SYNC + DC - 1) || pressed_o !== (k < SYNC + DC - 1) || press_o !== 1'b0) begin
                bad++;
                $display("FAIL release_latency k=%0d got rel=%b lvl=%b press=%b want rel=%b lvl=%b press=0",
                         k, release_o, pressed_o, press_o, k == SYNC + DC - 1, k < SYNC + DC - 1);
            end
        end
        repeat (3) @(negedge clk50_i);
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 15; k++) begin
            btn_i = (k < DC - 1);
            @(negedge clk50_i);
            total++;
            if (press_o !== 1'b0 || pressed_o !== 1'b0) begin
                bad++;
                $display("FAIL glitch k=%0d got press=%b lvl=%b want 0 0", k, press_o, pressed_o);
            end
        end
    endtask

    task automatic test_bounce_release();
        btn_i = 1'b1;
        wait_pressed(1'b1);
        // s last falls after edge 6 of this pattern; release follows DC edges later
        for (int j = 0; j < 14; j++) begin
            btn_i = (j == 2 || j == 3);
            @(negedge clk50_i);
            total++;
            if (release_o !== (j == 6 + DC) || pressed_o !== (j < 6 + DC) || press_o !== 1'b0) begin
                bad++;
                $display("FAIL bounce_release j=%0d got rel=%b lvl=%b press=%b want rel=%b lvl=%b press=0",
                         j, release_o, pressed_o, press_o, j == 6 + DC, j < 6 + DC);
            end
        end
    endtask

    task automatic test_reset_held();
        btn_i = 1'b1;
        wait_pressed(1'b1);
        repeat (2) @(negedge clk50_i);
        #2 rstn_i = 1'b0;
        #1;
        total++;
        if ({press_o, release_o, pressed_o, repeat_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async got=%b%b%b%b want=0000", press_o, release_o, pressed_o, repeat_o);
        end
        @(negedge clk50_i);
        @(negedge clk50_i);
        total++;
        if ({press_o, release_o, pressed_o, repeat_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold got=%b%b%b%b want=0000", press_o, release_o, pressed_o, repeat_o);
        end
        #2 rstn_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk50_i);
            total++;
            if (press_o !== (k == SYNC + DC - 1) || pressed_o !== (k >= SYNC + DC - 1) || release_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_held_press k=%0d got press=%b lvl=%b rel=%b want press=%b lvl=%b rel=0",
                         k, press_o, pressed_o, release_o, k == SYNC + DC - 1, k >= SYNC + DC - 1);
            end
        end
        btn_i = 1'b0;
        wait_pressed(1'b0);
        repeat (2) @(negedge clk50_i);
    endtask

    task automatic test_autorepeat();
        btn_i = 1'b1;
        wait_pressed(1'b1);
        for (int k = 1; k <= 40; k++) begin
            bit exp;
`ifdef BTN_AUTOREPEAT_EN
            exp = (k >= RD) && ((k - RD) % RP == 0);
`else
            exp = 1'b0;
`endif
            @(negedge clk50_i);
            total++;
            if (press_o !== exp || repeat_o !== exp) begin
                bad++;
                $display("FAIL autorepeat k=%0d got press=%b rep=%b want %b %b", k, press_o, repeat_o, exp, exp);
            end
        end
        btn_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk50_i);
            total++;
            if (press_o !== 1'b0 || repeat_o !== 1'b0) begin
                bad++;
                $display("FAIL repeat_after_release k=%0d got press=%b rep=%b want 0 0", k, press_o, repeat_o);
            end
        end
    endtask

    task automatic test_random();
        int presses = 0;
        for (int seg = 0; seg < 250; seg++) begin
            int len;
            len   = $urandom_range(1, 9);
            btn_i = $urandom_range(0, 1);
            repeat (len) begin
                @(negedge clk50_i);
                if (press_o) presses++;
            end
        end
        btn_i = 1'b0;
        repeat (12) @(negedge clk50_i);
        total++;
        if (pressed_o !== 1'b0) begin
            bad++;
            $display("FAIL random_final_level got=%b want=0 (presses seen %0d)", pressed_o, presses);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_press_latency();
        test_glitch();
        test_bounce_release();
        test_reset_held();
        test_autorepeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
